alu_status: RTL and testbench

Arithmetic status unit that sits directly downstream of the ALU. It registers the ALU flags (AZ, AN, AC, AV) into a 16-bit status word, ASTAT, and maintains a sticky overflow bit and a compare-history accumulator (CACC). It also evaluates 4-bit condition codes for conditional instructions issued by the program sequencer, and stalls the sequencer while a flag update is still in flight.

---
 rtl/alu_status_pkg.sv | 34 +++
 rtl/alu_cond_eval.sv | 58 +++++
 rtl/alu_status.sv | 94 +++++++++
 tb/tb_alu_status.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/alu_status_pkg.sv
// Shared definitions for the ALU status unit: ASTAT bit positions,
// condition-code encoding and the reserved-bit mask.
package alu_status_pkg;

  localparam int unsigned AZ_BIT   = 0;
  localparam int unsigned AN_BIT   = 1;
  localparam int unsigned AC_BIT   = 2;
  localparam int unsigned AV_BIT   = 3;
  localparam int unsigned AVS_BIT  = 4;
  localparam int unsigned CACC_LSB = 8;
  localparam int unsigned CACC_MSB = 15;

  localparam logic [15:0] RSVD_MASK = 16'h00E0;

  typedef enum logic [3:0] {
    CC_EQ     = 4'd0,
    CC_NE     = 4'd1,
    CC_LT     = 4'd2,
    CC_GE     = 4'd3,
    CC_LE     = 4'd4,
    CC_GT     = 4'd5,
    CC_AC     = 4'd6,
    CC_NAC    = 4'd7,
    CC_AV     = 4'd8,
    CC_NAV    = 4'd9,
    CC_CACC   = 4'd10,
    CC_NCACC  = 4'd11,
    CC_AVS    = 4'd12,
    CC_CACC2  = 4'd13,
    CC_TRUE   = 4'd14,
    CC_FALSE  = 4'd15
  } cond_code_e;

endpackage

// File: rtl/alu_cond_eval.sv
// Combinational condition-code evaluator over the registered ASTAT word.
// Compare-history codes depend on ALU_CACC_EN; without it they read FALSE.
module alu_cond_eval
  import alu_status_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic [3:0]            code,
  input  logic [DATA_WIDTH-1:0] astat,
  output logic                  result
);

  logic az, an, ac, av, avs;

  assign az  = astat[AZ_BIT];
  assign an  = astat[AN_BIT];
  assign ac  = astat[AC_BIT];
  assign av  = astat[AV_BIT];
  assign avs = astat[AVS_BIT];

`ifdef ALU_CACC_EN
  logic unused_bits;
  assign unused_bits = ^{astat[7:5], astat[CACC_MSB-2:CACC_LSB]};
`else
  logic unused_bits;
  assign unused_bits = ^{astat[7:5], astat[CACC_MSB:CACC_LSB]};
`endif

  always_comb begin
    result = 1'b0;
    case (cond_code_e'(code))
      CC_EQ:    result = az;
      CC_NE:    result = ~az;
      CC_LT:    result = an;
      CC_GE:    result = ~an;
      CC_LE:    result = an | az;
      CC_GT:    result = ~an & ~az;
      CC_AC:    result = ac;
      CC_NAC:   result = ~ac;
      CC_AV:    result = av;
      CC_NAV:   result = ~av;
`ifdef ALU_CACC_EN
      CC_CACC:  result = astat[CACC_MSB];
      CC_NCACC: result = ~astat[CACC_MSB];
      CC_CACC2: result = (astat[CACC_MSB -: 2] == 2'b11);
`else
      CC_CACC:  result = 1'b0;
      CC_NCACC: result = 1'b0;
      CC_CACC2: result = 1'b0;
`endif
      CC_AVS:   result = avs;
      CC_TRUE:  result = 1'b1;
      CC_FALSE: result = 1'b0;
      default:  result = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_status.sv
// ALU status register (ASTAT), sticky overflow, compare history and
// condition evaluation with stall. CACC flops exist only with ALU_CACC_EN.
module alu_status
  import alu_status_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CACC_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ps_alu_en,
  input  logic                  alu_ps_az,
  input  logic                  alu_ps_an,
  input  logic                  alu_ps_ac,
  input  logic                  alu_ps_av,
  input  logic                  alu_ps_compd,
  input  logic                  ps_astat_wen,
  input  logic [DATA_WIDTH-1:0] ps_astat_wdata,
  input  logic                  ps_stky_clr,
  input  logic                  ps_cond_vld,
  input  logic [3:0]            ps_cond_code,
  output logic                  stat_ps_cond_true,
  output logic                  stat_ps_stall,
  output logic [DATA_WIDTH-1:0] stat_xb_astat,
  output logic                  stat_ps_avs
);

  logic                  upd_pend;
  logic [3:0]            flags_q;
  logic                  avs_q;
  logic [CACC_W-1:0]     cacc_field;
  logic [DATA_WIDTH-1:0] wdata_m;
  logic                  cond_raw;

  assign wdata_m = ps_astat_wdata & ~RSVD_MASK;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) upd_pend <= 1'b0;
    else        upd_pend <= ps_alu_en;
  end

  // Flag update from the ALU outranks a software write of the same bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            flags_q <= '0;
    else if (upd_pend)     flags_q <= {alu_ps_av, alu_ps_ac, alu_ps_an, alu_ps_az};
    else if (ps_astat_wen) flags_q <= wdata_m[AV_BIT:AZ_BIT];
  end

  // An overflow in flight outranks both the sticky clear and a write of 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      avs_q <= 1'b0;
    else if (upd_pend && alu_ps_av)  avs_q <= 1'b1;
    else if (ps_stky_clr)            avs_q <= 1'b0;
    else if (ps_astat_wen)           avs_q <= wdata_m[AVS_BIT];
  end

`ifdef ALU_CACC_EN
  logic [CACC_W-1:0] cacc_q;

  // New MSB marks x > y; history shifts toward the LSB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       cacc_q <= '0;
    else if (upd_pend && alu_ps_compd) cacc_q <= {~alu_ps_az & ~alu_ps_an, cacc_q[CACC_W-1:1]};
    else if (ps_astat_wen)            cacc_q <= wdata_m[CACC_MSB:CACC_LSB];
  end

  assign cacc_field = cacc_q;

  logic unused_wdata;
  assign unused_wdata = ^{wdata_m[7:5], alu_ps_compd & 1'b0};
`else
  assign cacc_field = '0;

  logic unused_wdata;
  assign unused_wdata = ^{wdata_m[7:5], wdata_m[CACC_MSB:CACC_LSB], alu_ps_compd};
`endif

  assign stat_xb_astat = {cacc_field, 3'b000, avs_q, flags_q};
  assign stat_ps_avs   = avs_q;

  alu_cond_eval #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cond_eval (
    .code   (ps_cond_code),
    .astat  (stat_xb_astat),
    .result (cond_raw)
  );

  // No flag bypass: while an update is pending the request stalls and the
  // result is suppressed; reset also forces the result low.
  assign stat_ps_stall     = ps_cond_vld & upd_pend;
  assign stat_ps_cond_true = ps_cond_vld & ~upd_pend & reset & cond_raw;

endmodule

// File: tb/tb_alu_status.sv
// Scoreboard bench for alu_status: stimulus pushes expected status per
// cycle, a negedge monitor pops and compares. Honours ALU_CACC_EN.
module tb_alu_status;
  import alu_status_pkg::*;

`ifdef ALU_CACC_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ps_alu_en, alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av, alu_ps_compd;
  logic        ps_astat_wen, ps_stky_clr, ps_cond_vld;
  logic [15:0] ps_astat_wdata;
  logic [3:0]  ps_cond_code;
  logic        stat_ps_cond_true, stat_ps_stall, stat_ps_avs;
  logic [15:0] stat_xb_astat;

  typedef struct {
    string       nm;
    logic [15:0] astat;
    logic        ct;
    logic        st;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  alu_status #(
    .DATA_WIDTH (16),
    .CACC_W     (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .ps_alu_en         (ps_alu_en),
    .alu_ps_az         (alu_ps_az),
    .alu_ps_an         (alu_ps_an),
    .alu_ps_ac         (alu_ps_ac),
    .alu_ps_av         (alu_ps_av),
    .alu_ps_compd      (alu_ps_compd),
    .ps_astat_wen      (ps_astat_wen),
    .ps_astat_wdata    (ps_astat_wdata),
    .ps_stky_clr       (ps_stky_clr),
    .ps_cond_vld       (ps_cond_vld),
    .ps_cond_code      (ps_cond_code),
    .stat_ps_cond_true (stat_ps_cond_true),
    .stat_ps_stall     (stat_ps_stall),
    .stat_xb_astat     (stat_xb_astat),
    .stat_ps_avs       (stat_ps_avs)
  );

  always #5 clk = ~clk;

  // Monitor: every cycle with a pending expectation is compared at negedge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (stat_xb_astat === e.astat && stat_ps_avs === e.astat[AVS_BIT] &&
          stat_ps_cond_true === e.ct && stat_ps_stall === e.st)
        n_pass++;
      else
        $display("FAIL %s: astat=%h avs=%b cond=%b stall=%b, expected astat=%h avs=%b cond=%b stall=%b",
                 e.nm, stat_xb_astat, stat_ps_avs, stat_ps_cond_true, stat_ps_stall,
                 e.astat, e.astat[AVS_BIT], e.ct, e.st);
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
    ps_alu_en = 0; alu_ps_az = 0; alu_ps_an = 0; alu_ps_ac = 0; alu_ps_av = 0;
    alu_ps_compd = 0; ps_astat_wen = 0; ps_astat_wdata = '0; ps_stky_clr = 0;
    ps_cond_vld = 0; ps_cond_code = 4'd0;
  endtask

  task automatic expect_now(input string nm, input logic [15:0] a, input logic ct, input logic st);
    exp_t e;
    e.nm = nm; e.astat = a; e.ct = ct; e.st = st;
    q.push_back(e);
  endtask

  task automatic cond(input logic [3:0] c);
    ps_cond_vld = 1; ps_cond_code = c;
  endtask

  task automatic flags(input logic az, input logic an, input logic ac, input logic av, input logic cmp);
    alu_ps_az = az; alu_ps_an = an; alu_ps_ac = ac; alu_ps_av = av; alu_ps_compd = cmp;
  endtask

  initial begin
    reset = 0;
    go(); cond(4'd14);                  expect_now("reset_state", 16'h0000, 0, 0);
    go(); reset = 1;                    expect_now("release", 16'h0000, 0, 0);
    go(); cond(4'd14);                  expect_now("idle_true", 16'h0000, 1, 0);

    go(); ps_alu_en = 1;                expect_now("issue_n", 16'h0000, 0, 0);
    go(); flags(0,1,0,1,0); cond(4'd2); expect_now("stall_n1", 16'h0000, 0, 1);
    go(); cond(4'd2);                   expect_now("lt_n2", 16'h001A, 1, 0);

    go(); ps_alu_en = 1;                expect_now("sticky_issue", 16'h001A, 0, 0);
    go(); flags(1,0,1,1,0); ps_stky_clr = 1; expect_now("clr_vs_av", 16'h001A, 0, 0);
    go(); ps_stky_clr = 1;              expect_now("avs_kept", 16'h001D, 0, 0);
    go(); cond(4'd12);                  expect_now("avs_cleared", 16'h000D, 0, 0);

    go(); ps_alu_en = 1;                expect_now("comp_issue", 16'h000D, 0, 0);
    go(); ps_alu_en = 1; flags(0,0,1,0,1); cond(4'd0); expect_now("comp1", 16'h000D, 0, 1);
    go(); ps_alu_en = 1; flags(0,1,0,0,1); cond(4'd0); expect_now("comp2", CE ? 16'h8004 : 16'h0004, 0, 1);
    go(); flags(0,0,0,0,1); cond(4'd0); expect_now("comp3", CE ? 16'h4002 : 16'h0002, 0, 1);
    go(); cond(4'd10);                  expect_now("cacc_msb", CE ? 16'hA000 : 16'h0000, CE, 0);
    go(); cond(4'd13);                  expect_now("cacc_two", CE ? 16'hA000 : 16'h0000, 0, 0);
    go(); cond(4'd11);                  expect_now("cacc_nmsb", CE ? 16'hA000 : 16'h0000, 0, 0);

    go(); ps_astat_wen = 1; ps_astat_wdata = 16'hFFFF; cond(4'd14);
                                        expect_now("wr_ffff_n", CE ? 16'hA000 : 16'h0000, 1, 0);
    go(); cond(4'd13);                  expect_now("wr_ffff", CE ? 16'hFF1F : 16'h001F, CE, 0);
    go(); cond(4'd12);                  expect_now("avs_written", CE ? 16'hFF1F : 16'h001F, 1, 0);

    go(); ps_alu_en = 1;                expect_now("prio_issue", CE ? 16'hFF1F : 16'h001F, 0, 0);
    go(); flags(0,0,1,1,1); ps_astat_wen = 1; ps_astat_wdata = 16'h0000;
                                        expect_now("prio_cycle", CE ? 16'hFF1F : 16'h001F, 0, 0);
    go(); cond(4'd8);                   expect_now("prio_result", CE ? 16'hFF1C : 16'h001C, 1, 0);

    go(); ps_astat_wen = 1; ps_astat_wdata = 16'h12E5;
                                        expect_now("wr_rsvd_n", CE ? 16'hFF1C : 16'h001C, 0, 0);
    go(); cond(4'd4);                   expect_now("wr_rsvd", CE ? 16'h1205 : 16'h0005, 1, 0);

    go(); ps_alu_en = 1;                expect_now("rst_issue", CE ? 16'h1205 : 16'h0005, 0, 0);
    go(); reset = 0; flags(1,1,1,1,1); cond(4'd14);
                                        expect_now("rst_mid", 16'h0000, 0, 0);
    go(); reset = 1; cond(4'd5);        expect_now("rst_discard", 16'h0000, 1, 0);
    go(); cond(4'd15);                  expect_now("false_code", 16'h0000, 0, 0);

    go(); go();
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: pending=%0d, expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
